// File: rtl/dual_periodic_trigger_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dual_periodic_trigger_sched_pkg
// Description : Shared types and the round-robin pick helper for the
//               dual-channel periodic trigger scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package dual_periodic_trigger_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef logic chan_id_t;

    localparam chan_id_t c_chan1 = 1'b0;
    localparam chan_id_t c_chan2 = 1'b1;

    // On a tie the channel that did not win last time is chosen.
    function automatic chan_id_t rr_pick(input logic [1:0] avail, input chan_id_t last_gnt);
        if (&avail) begin
            return ~last_gnt;
        end
        return (avail == 2'b10) ? c_chan2 : c_chan1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dual_periodic_trigger_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : dual_periodic_trigger_sched_if
// Description : Shared report port (valid/ready handshake plus report fields).
// Revision    : 1.0 - initial release
// ============================================================================
interface dual_periodic_trigger_sched_if #(
    parameter int CNT_W  = 16,
    parameter int TIME_W = 16
) ();
    logic              out_valid;
    logic              out_ready;
    logic              out_id;
    logic [CNT_W-1:0]  out_count;
    logic [TIME_W-1:0] out_time;

    modport master (
        output out_valid,
        output out_id,
        output out_count,
        output out_time,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_id,
        input  out_count,
        input  out_time,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/dual_periodic_trigger_sched_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : periodic_tick_gen
// Description : Flags the cycles whose elapsed count is a multiple of PERIOD.
// Revision    : 1.0 - initial release
// ============================================================================
module periodic_tick_gen #(
    parameter int PERIOD = 2,
    parameter int TIME_W = 16
) (
    input  logic              en,
    input  logic [TIME_W-1:0] elapsed,
    output logic              tick
);

    generate
        if (PERIOD == 1) begin : g_every_cycle
            assign tick = en;
        end else begin : g_modulo
            localparam logic [TIME_W-1:0] c_period = TIME_W'(PERIOD);
            assign tick = en && ((elapsed % c_period) == '0);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/dual_periodic_trigger_sched.sv
`default_nettype none
// ============================================================================
// Module      : dual_periodic_trigger_sched
// Description : Two-channel periodic trigger scheduler sharing one report port,
//               with run window, drain, done pulse and held trigger counts.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_periodic_trigger_sched
    import dual_periodic_trigger_sched_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int TIME_W     = 16,
    parameter int PERIOD1    = 2,
    parameter int PERIOD2    = 4,
    parameter int RUN_CYCLES = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    dual_periodic_trigger_sched_if.master rpt,
    output logic                          busy,
    output logic                          done,
    output logic [CNT_W-1:0]              cnt1,
    output logic [CNT_W-1:0]              cnt2,
    output logic [CNT_W-1:0]              drop1,
    output logic [CNT_W-1:0]              drop2
);

    typedef struct packed {
        chan_id_t          id;
        logic [CNT_W-1:0]  count;
        logic [TIME_W-1:0] tstamp;
    } report_t;

    localparam logic [TIME_W-1:0] c_last_elapsed = TIME_W'(RUN_CYCLES - 1);
    localparam logic [TIME_W-1:0] c_time_one     = {{(TIME_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  c_cnt_one      = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + c_cnt_one;
    endfunction

    state_e              r_state;
    state_e              w_state_nxt;
    logic [TIME_W-1:0]   r_elapsed;
    logic                w_run;
    logic                w_start_run;
    logic                w_last_tick;
    logic [1:0]          w_tick;
    logic [1:0]          w_pend;
    logic [1:0]          w_avail;
    logic [1:0]          w_gnt;
    logic                w_load;
    chan_id_t            w_gnt_id;
    chan_id_t            r_last;
    logic                r_valid;
    report_t             r_out;
    report_t [1:0]       w_eff;
    logic [1:0][CNT_W-1:0] w_cnt;
    logic [1:0][CNT_W-1:0] w_drop;

    assign w_start_run = (r_state == IDLE) && start;
    assign w_last_tick = (r_elapsed == c_last_elapsed);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = RUN;
            RUN:     if (w_last_tick) w_state_nxt = DRAIN;
            DRAIN:   if (!(|w_pend) && !r_valid) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        w_run = 1'b0;
        case (r_state)
            RUN: begin
                busy  = 1'b1;
                w_run = 1'b1;
            end
            DRAIN:   busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The counter parks on the last window cycle so it never wraps mid-run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_elapsed <= '0;
        end else if (w_start_run) begin
            r_elapsed <= '0;
        end else if (w_run && !w_last_tick) begin
            r_elapsed <= r_elapsed + c_time_one;
        end
    end

    // ---------------- Per-channel tick, count and pending capture ----------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        localparam int c_period = (gi == 0) ? PERIOD1 : PERIOD2;

        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_drop;
        logic [CNT_W-1:0] w_cnt_inc;
        logic             r_pend;
        report_t          r_cap;
        report_t          w_new;

        periodic_tick_gen #(
            .PERIOD (c_period),
            .TIME_W (TIME_W)
        ) u_tick (
            .en      (w_run),
            .elapsed (r_elapsed),
            .tick    (w_tick[gi])
        );

        assign w_cnt_inc  = sat_inc(r_cnt);
        assign w_new      = '{id: 1'(gi), count: w_cnt_inc, tstamp: r_elapsed};
        // A fresh tick bypasses the capture register when nothing is pending.
        assign w_eff[gi]  = r_pend ? r_cap : w_new;
        assign w_pend[gi] = r_pend;
        assign w_cnt[gi]  = r_cnt;
        assign w_drop[gi] = r_drop;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt  <= '0;
                r_drop <= '0;
                r_pend <= 1'b0;
                r_cap  <= '0;
            end else if (w_start_run) begin
                r_cnt  <= '0;
                r_drop <= '0;
                r_pend <= 1'b0;
            end else if (w_tick[gi]) begin
                r_cnt <= w_cnt_inc;
                if (r_pend && !w_gnt[gi]) begin
                    r_drop <= sat_inc(r_drop);
                end else begin
                    r_pend <= r_pend | ~w_gnt[gi];
                    r_cap  <= w_new;
                end
            end else if (w_gnt[gi]) begin
                r_pend <= 1'b0;
            end
        end
    end

    // ---------------- Arbiter and output register ----------------
    assign w_avail  = w_pend | w_tick;
    assign w_load   = (!r_valid || rpt.out_ready) && (|w_avail);
    assign w_gnt_id = rr_pick(w_avail, r_last);
    assign w_gnt    = !w_load ? 2'b00 : (w_gnt_id == c_chan2) ? 2'b10 : 2'b01;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_out   <= '0;
            r_last  <= c_chan2;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_out   <= w_eff[w_gnt_id];
            r_last  <= w_gnt_id;
        end else if (rpt.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign rpt.out_valid = r_valid;
    assign rpt.out_id    = r_out.id;
    assign rpt.out_count = r_out.count;
    assign rpt.out_time  = r_out.tstamp;

    assign cnt1  = w_cnt[0];
    assign cnt2  = w_cnt[1];
    assign drop1 = w_drop[0];
    assign drop2 = w_drop[1];

endmodule
`default_nettype wire

// File: tb/tb_dual_periodic_trigger_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_periodic_trigger_sched
// Description : Self-checking bench: vector table, queue-based reference model
//               with random back-pressure, reset and parameter-variant cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_periodic_trigger_sched;

    localparam int CNT_W  = 16;
    localparam int TIME_W = 16;
    localparam int P1     = 2;
    localparam int P2     = 4;
    localparam int RC     = 20;

    localparam int PH_IDLE  = 0;
    localparam int PH_RUN   = 1;
    localparam int PH_DRAIN = 2;
    localparam int PH_DONE  = 3;

    logic clk;
    logic rst;
    logic start;
    logic start_b;
    logic busy, done, busy_b, done_b;
    logic [CNT_W-1:0] cnt1, cnt2, drop1, drop2;
    logic [CNT_W-1:0] cnt1_b, cnt2_b, drop1_b, drop2_b;

    dual_periodic_trigger_sched_if #(.CNT_W(CNT_W), .TIME_W(TIME_W)) rif ();
    dual_periodic_trigger_sched_if #(.CNT_W(CNT_W), .TIME_W(TIME_W)) rif_b ();

    dual_periodic_trigger_sched #(
        .CNT_W(CNT_W), .TIME_W(TIME_W), .PERIOD1(P1), .PERIOD2(P2), .RUN_CYCLES(RC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .rpt(rif),
        .busy(busy), .done(done), .cnt1(cnt1), .cnt2(cnt2), .drop1(drop1), .drop2(drop2)
    );

    dual_periodic_trigger_sched #(
        .CNT_W(CNT_W), .TIME_W(TIME_W), .PERIOD1(3), .PERIOD2(7), .RUN_CYCLES(20)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .rpt(rif_b),
        .busy(busy_b), .done(done_b), .cnt1(cnt1_b), .cnt2(cnt2_b), .drop1(drop1_b), .drop2(drop2_b)
    );

    assign rif_b.out_ready = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_err;
    int n_acc;
    int n_done;
    logic              acc_id [64];
    logic [TIME_W-1:0] acc_tm [64];

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- Reference model: one-deep per-channel queues ----------------
    typedef struct { int id; int count; int tm; } mrep_t;
    mrep_t mq0[$];
    mrep_t mq1[$];
    int    m_phase, m_e, m_last;
    int    m_cnt [2];
    int    m_drop [2];
    bit    m_valid;
    mrep_t m_out;

    function automatic void model_reset();
        mq0.delete();
        mq1.delete();
        m_phase = PH_IDLE;
        m_e = 0;
        m_last = 1;
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_drop[0] = 0; m_drop[1] = 0;
        m_valid = 0;
        m_out = '{0, 0, 0};
    endfunction

    function automatic void model_edge(input bit rdy, input bit st);
        bit    fin;
        bit    load;
        int    g;
        mrep_t r;
        fin = (mq0.size() == 0) && (mq1.size() == 0) && !m_valid;
        if (m_phase == PH_RUN) begin
            if (m_e % P1 == 0) begin m_cnt[0]++; r = '{0, m_cnt[0], m_e}; mq0.push_back(r); end
            if (m_e % P2 == 0) begin m_cnt[1]++; r = '{1, m_cnt[1], m_e}; mq1.push_back(r); end
        end
        load = (!m_valid || rdy) && (mq0.size() > 0 || mq1.size() > 0);
        if (load) begin
            if (mq0.size() > 0 && mq1.size() > 0) g = 1 - m_last;
            else g = (mq0.size() > 0) ? 0 : 1;
            if (g == 0) m_out = mq0.pop_front();
            else        m_out = mq1.pop_front();
            m_valid = 1;
            m_last  = g;
        end else if (rdy) begin
            m_valid = 0;
        end
        // A newer report arriving behind a waiting one is lost.
        if (mq0.size() > 1) begin void'(mq0.pop_back()); m_drop[0]++; end
        if (mq1.size() > 1) begin void'(mq1.pop_back()); m_drop[1]++; end
        case (m_phase)
            PH_IDLE:  if (st) begin
                          m_phase = PH_RUN; m_e = 0;
                          m_cnt[0] = 0; m_cnt[1] = 0; m_drop[0] = 0; m_drop[1] = 0;
                      end
            PH_RUN:   if (m_e == RC - 1) m_phase = PH_DRAIN; else m_e++;
            PH_DRAIN: if (fin) m_phase = PH_DONE;
            default:  m_phase = PH_IDLE;
        endcase
    endfunction

    task automatic compare_all();
        chk("out_valid", 64'(rif.out_valid), 64'(m_valid));
        if (m_valid)
            chk("report", {31'd0, rif.out_id, rif.out_count, rif.out_time},
                {31'd0, 1'(m_out.id), 16'(m_out.count), 16'(m_out.tm)});
        chk("busy_done", {62'd0, busy, done},
            {62'd0, (m_phase == PH_RUN || m_phase == PH_DRAIN), (m_phase == PH_DONE)});
        chk("counters", {cnt1, cnt2, drop1, drop2},
            {16'(m_cnt[0]), 16'(m_cnt[1]), 16'(m_drop[0]), 16'(m_drop[1])});
    endtask

    task automatic step();
        logic              acc;
        logic              aid;
        logic [TIME_W-1:0] atm;
        acc = rif.out_valid && rif.out_ready;
        aid = rif.out_id;
        atm = rif.out_time;
        @(posedge clk);
        if (acc) begin
            if (n_acc < 64) begin acc_id[n_acc] = aid; acc_tm[n_acc] = atm; end
            n_acc++;
        end
        model_edge(rif.out_ready, start);
        #1;
        compare_all();
        if (done) n_done++;
    endtask

    // pct < 0: ready low for run cycles 0..low_n-1, high otherwise.
    task automatic do_run(input int low_n, input int repulse, input int pct);
        bit fin;
        fin = 0;
        n_acc = 0;
        n_done = 0;
        for (int c = 0; c < 200 && !fin; c++) begin
            start = (c == 0) || (c == repulse);
            if (pct >= 0) rif.out_ready = (int'($urandom_range(99)) < pct);
            else          rif.out_ready = !(c >= 1 && c <= low_n);
            step();
            if (c > 0 && m_phase == PH_IDLE) fin = 1;
        end
        start = 1'b0;
        rif.out_ready = 1'b1;
        chk("run_finished", 64'(fin), 64'd1);
    endtask

    typedef struct { int low_n; int repulse; int c1; int c2; int d1; int d2; int nrep; } vec_t;
    vec_t vec [5];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TIME_W-1:0] last1, last2;
        bit                seen_done;
        bit                hit;

        vec[0] = '{0, -1, 10, 5, 0, 0, 15};
        vec[1] = '{2, -1, 10, 5, 0, 0, 15};
        vec[2] = '{4, -1, 10, 5, 1, 0, 14};
        vec[3] = '{8, -1, 10, 5, 3, 1, 11};
        vec[4] = '{0,  6, 10, 5, 0, 0, 15};

        n_checks = 0; n_err = 0; n_acc = 0; n_done = 0;
        rst = 1'b1; start = 1'b0; start_b = 1'b0; rif.out_ready = 1'b1;
        model_reset();
        #12;
        compare_all();
        chk("reset_report", {31'd0, rif.out_id, rif.out_count, rif.out_time}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) step();

        for (int i = 0; i < 5; i++) begin
            do_run(vec[i].low_n, vec[i].repulse, -1);
            chk("cnt1", 64'(cnt1), 64'(vec[i].c1));
            chk("cnt2", 64'(cnt2), 64'(vec[i].c2));
            chk("drop1", 64'(drop1), 64'(vec[i].d1));
            chk("drop2", 64'(drop2), 64'(vec[i].d2));
            chk("num_reports", 64'(n_acc), 64'(vec[i].nrep));
            chk("done_pulses", 64'(n_done), 64'd1);
            chk("busy_after", 64'(busy), 64'd0);
            if (i == 0) begin
                chk("rr_first",  {acc_id[0], acc_tm[0]}, {1'b0, 16'd0});
                chk("rr_second", {acc_id[1], acc_tm[1]}, {1'b1, 16'd0});
                chk("rr_e4_a",   {acc_id[3], acc_tm[3]}, {1'b1, 16'd4});
                chk("rr_e4_b",   {acc_id[4], acc_tm[4]}, {1'b0, 16'd4});
            end
            repeat (2) step();
        end

        for (int r = 0; r < 3; r++) begin
            do_run(0, -1, 35 + 20 * r);
            chk("rand_cnt1", 64'(cnt1), 64'd10);
            chk("rand_cnt2", 64'(cnt2), 64'd5);
            chk("rand_conserve", 64'(n_acc + int'(drop1) + int'(drop2)), 64'd15);
            repeat (3) step();
        end

        // Asynchronous reset in the middle of a run.
        n_done = 0;
        hit = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            step();
            if (m_phase == PH_RUN && m_e == 7) hit = 1;
        end
        chk("reached_e7", 64'(hit), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ctl", {61'd0, rif.out_valid, busy, done}, 64'd0);
        chk("async_rst_rpt", {31'd0, rif.out_id, rif.out_count, rif.out_time}, 64'd0);
        chk("async_rst_cnt", {cnt1, cnt2, drop1, drop2}, 64'd0);
        chk("no_done_on_rst", 64'(n_done), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) step();
        do_run(0, -1, -1);
        chk("post_rst_cnt", {32'd0, cnt1, cnt2}, {32'd0, 16'd10, 16'd5});
        chk("post_rst_reports", 64'(n_acc), 64'd15);

        // Alternate periods on the second instance.
        last1 = '0; last2 = '0; seen_done = 0;
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int c = 0; c < 100 && !seen_done; c++) begin
            if (rif_b.out_valid) begin
                if (rif_b.out_id) last2 = rif_b.out_time;
                else              last1 = rif_b.out_time;
            end
            @(posedge clk);
            #1;
            if (done_b) seen_done = 1;
        end
        chk("b_done", 64'(seen_done), 64'd1);
        chk("b_cnt1", 64'(cnt1_b), 64'd7);
        chk("b_cnt2", 64'(cnt2_b), 64'd3);
        chk("b_drops", {32'd0, drop1_b, drop2_b}, 64'd0);
        chk("b_last1", 64'(last1), 64'd18);
        chk("b_last2", 64'(last2), 64'd14);
        @(posedge clk);
        #1;
        chk("b_busy_after", 64'(busy_b), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
